// File: rtl/syn_fifo_gen2.sv
// Single-clock synchronous FIFO with level, threshold flags, error pulses and flush.
// Define SYN_FIFO_GEN2_FWFT_EN for first-word-fall-through output behaviour.
module syn_fifo_gen2 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LW    = ADDR_WIDTH + 1;

  if (!((AE_LEVEL > 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_param_check
    $fatal(1, "syn_fifo_gen2: require 0 < AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic rd_acc;
  logic wr_acc;
  logic mem_rd;

  assign full         = (level_q == LW'(DEPTH));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LW'(AF_LEVEL));
  assign almost_empty = (level_q <= LW'(AE_LEVEL));
  assign level        = level_q;
  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

`ifdef SYN_FIFO_GEN2_FWFT_EN
  // level includes the word parked in the output register; the rest sits in mem.
  logic [LW-1:0] mem_cnt;
  assign mem_cnt = level_q - LW'(data_valid_q);
  assign rd_acc  = rd_en && data_valid_q;
  assign mem_rd  = (!data_valid_q || rd_acc) && (mem_cnt != '0);
`else
  assign rd_acc  = rd_en && !empty;
  assign mem_rd  = rd_acc;
`endif

  // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (mem_rd) begin
        rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
        data_out_d = mem[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
`ifdef SYN_FIFO_GEN2_FWFT_EN
      data_valid_d = mem_rd || (data_valid_q && !rd_acc);
`else
      data_valid_d = rd_acc;
`endif
      overflow_d  = wr_en && !wr_acc;
      underflow_d = rd_en && !rd_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !clr) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

endmodule
